// File: rtl/rv32_instr_encoder_pkg.sv
// rtl/rv32_instr_encoder_pkg.sv - shared RV32I opcode defines, format enum and request record
package rv32_instr_encoder_pkg;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_ARITH_I = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_ARITH_R = 5'b01100;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // Unknown opcodes fall back to I-format so the loader never stalls on them.
  function automatic fmt_e opcode_fmt(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_STORE:          f = FMT_S;
      OP_BRANCH:         f = FMT_B;
      OP_LUI, OP_AUIPC:  f = FMT_U;
      OP_JAL:            f = FMT_J;
      OP_ARITH_R:        f = FMT_R;
      default:           f = FMT_I;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32_imm_pack.sv
// rtl/rv32_imm_pack.sv - scatters fields and a flat immediate into one RV32I instruction word
module rv32_imm_pack
  import rv32_instr_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [4:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
      FMT_U: word = {imm[31:12], rd, opcode, 2'b11};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
      default: word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};
    endcase
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// rtl/rv32_instr_encoder.sv - two-stage RV32I packer feeding the program loader with addressed words
module rv32_instr_encoder
  import rv32_instr_encoder_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              range_err,
  output logic [ADDR_W-1:0] err_addr
);

  enc_req_t          req_in;
  enc_req_t          s1_req;
  logic              s1_valid;
  logic              s1_bad;
  logic              bad_in;
  logic              s2_ready;
  logic              s1_adv;
  logic [31:0]       packed_word;
  logic [ADDR_W-1:0] addr_cnt;
  logic signed [31:0] simm;

  assign req_in = '{
    fmt:    opcode_fmt(opcode),
    opcode: opcode,
    rd:     rd,
    rs1:    rs1,
    rs2:    rs2,
    funct3: funct3,
    funct7: funct7,
    imm:    imm
  };

  assign simm = $signed(imm);

  always_comb begin
    bad_in = 1'b0;
    case (req_in.fmt)
      FMT_I, FMT_S: bad_in = (simm < -2048) || (simm > 2047);
      FMT_B:        bad_in = (simm < -4096) || (simm > 4094) || imm[0];
      FMT_J:        bad_in = (simm < -1048576) || (simm > 1048574) || imm[0];
      FMT_U:        bad_in = |imm[11:0];
      default:      bad_in = 1'b0;
    endcase
  end

  // A bad request still takes its turn in stage 2 so ordering against the address counter is exact.
  assign s2_ready = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s1_adv;

  rv32_imm_pack u_pack (
    .fmt    (s1_req.fmt),
    .opcode (s1_req.opcode),
    .rd     (s1_req.rd),
    .rs1    (s1_req.rs1),
    .rs2    (s1_req.rs2),
    .funct3 (s1_req.funct3),
    .funct7 (s1_req.funct7),
    .imm    (s1_req.imm),
    .word   (packed_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_req    <= '0;
      s1_bad    <= 1'b0;
      out_valid <= 1'b0;
      instr     <= '0;
      addr      <= BASE_ADDR;
      addr_cnt  <= BASE_ADDR;
      range_err <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_req <= req_in;
          s1_bad <= bad_in;
        end
      end

      if (s2_ready) begin
        out_valid <= s1_valid && !s1_bad;
      end

      if (s1_adv && !s1_bad) begin
        instr <= packed_word;
        addr  <= addr_cnt;
      end

      // The emitted word above keeps its pre-clear address; only the counter restarts.
      if (clear) begin
        addr_cnt  <= BASE_ADDR;
        range_err <= 1'b0;
        err_addr  <= '0;
      end else if (s1_adv) begin
        if (s1_bad) begin
          if (!range_err) begin
            range_err <= 1'b1;
            err_addr  <= addr_cnt;
          end
        end else begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb/tb_rv32_instr_encoder.sv - randomized self-checking bench with a behavioural encoder model
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;

  logic        in_ready, out_valid, range_err;
  logic [31:0] instr;
  logic [9:0]  addr, err_addr;
  logic        in_ready2, out_valid2, range_err2;
  logic [31:0] instr2;
  logic [1:0]  addr2, err_addr2;

  always #5 clk = ~clk;

  rv32_instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clr), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .range_err(range_err), .err_addr(err_addr)
  );

  rv32_instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .instr(instr2), .addr(addr2),
    .range_err(range_err2), .err_addr(err_addr2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Model: 0=R 1=I 2=S 3=B 4=U 5=J
  function automatic int mfmt(input logic [4:0] op);
    case (op)
      5'b01000:          return 2;
      5'b11000:          return 3;
      5'b01101, 5'b00101: return 4;
      5'b11011:          return 5;
      5'b01100:          return 0;
      default:           return 1;
    endcase
  endfunction

  function automatic bit mbad(input int f, input logic [31:0] im);
    int s;
    s = int'(im);
    case (f)
      1, 2:    return (s < -2048) || (s > 2047);
      3:       return (s < -4096) || (s > 4094) || (im % 2 != 0);
      4:       return (im % 4096) != 0;
      5:       return (s < -1048576) || (s > 1048574) || (im % 2 != 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo, input int dst);
    logic [31:0] m;
    m = (32'h1 << (hi - lo + 1)) - 32'h1;
    return ((v >> lo) & m) << dst;
  endfunction

  function automatic logic [31:0] menc(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] im);
    logic [31:0] w;
    w = (32'(op) << 2) + 32'd3;
    case (mfmt(op))
      0: w = w + (32'(d) << 7) + (32'(f3) << 12) + (32'(s1) << 15) + (32'(s2) << 20) + (32'(f7) << 25);
      2: w = w + bits(im, 4, 0, 7) + (32'(f3) << 12) + (32'(s1) << 15) + (32'(s2) << 20) + bits(im, 11, 5, 25);
      3: w = w + bits(im, 11, 11, 7) + bits(im, 4, 1, 8) + (32'(f3) << 12) + (32'(s1) << 15)
             + (32'(s2) << 20) + bits(im, 10, 5, 25) + bits(im, 12, 12, 31);
      4: w = w + (32'(d) << 7) + (im & 32'hFFFFF000);
      5: w = w + (32'(d) << 7) + bits(im, 19, 12, 12) + bits(im, 11, 11, 20) + bits(im, 10, 1, 21)
             + bits(im, 20, 20, 31);
      default: w = w + (32'(d) << 7) + (32'(f3) << 12) + (32'(s1) << 15) + bits(im, 11, 0, 20);
    endcase
    return w;
  endfunction

  // Core-side immediate decode, used for the round-trip invariant.
  function automatic logic [31:0] mdec(input logic [31:0] i);
    case (mfmt(i[6:2]))
      2: return {{20{i[31]}}, i[31:25], i[11:7]};
      3: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      4: return {i[31:12], 12'b0};
      5: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  typedef struct {
    logic [31:0] w;
    int          a;
    logic [31:0] rt;
    bit          has_rt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] log_i[$];
  int          log_a[$];
  int          log_a2[$];
  int          m_cnt = 0;
  bit          m_err = 0;
  int          m_err_addr = 0;
  bit          model_on = 1;
  bit          saw_full = 0;
  bit          prev_stall = 0;
  logic [31:0] held_i;
  logic [9:0]  held_a;

  task automatic model_accept();
    int f;
    exp_t e;
    f = mfmt(opcode);
    if (mbad(f, imm)) begin
      if (!m_err) begin
        m_err = 1;
        m_err_addr = m_cnt;
      end
    end else begin
      e.w = menc(opcode, rd, rs1, rs2, funct3, funct7, imm);
      e.a = m_cnt;
      e.rt = (f == 4) ? (imm & 32'hFFFFF000) : imm;
      e.has_rt = (f != 0);
      q.push_back(e);
      m_cnt++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_instr", 64'(instr), 64'(held_i));
          chk("stall_addr", 64'(addr), 64'(held_a));
        end
        if (!out_valid || out_ready) chk("in_ready_free", 64'(in_ready), 64'd1);
        if (in_valid && !in_ready) saw_full = 1;
        if (in_valid && in_ready && model_on) model_accept();
        if (out_valid && out_ready) begin
          log_i.push_back(instr);
          log_a.push_back(int'(addr));
          log_a2.push_back(int'(addr2));
          chk("dut2_valid", 64'(out_valid2), 64'd1);
          if (model_on) begin
            chk("word_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
              exp_t e;
              e = q.pop_front();
              chk("instr", 64'(instr), 64'(e.w));
              chk("addr", 64'(addr), 64'(e.a % 1024));
              chk("addr_w2", 64'(addr2), 64'(e.a % 4));
              if (e.has_rt) chk("round_trip", 64'(mdec(instr)), 64'(e.rt));
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        held_i = instr;
        held_a = addr;
      end else begin
        prev_stall = 0;
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    int k;
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_idle();
    int quiet, k;
    quiet = 0; k = 0;
    out_ready = 1;
    while (quiet < 4 && k < 1000) begin
      @(negedge clk);
      if (!out_valid && !in_valid) quiet++;
      else quiet = 0;
      k++;
    end
    if (quiet < 4) chk("idle_timeout", 64'(quiet), 64'd4);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    m_cnt = 0; m_err = 0; m_err_addr = 0;
  endtask

  task automatic chk_err();
    chk("range_err", 64'(range_err), 64'(m_err));
    chk("err_addr", 64'(err_addr), 64'(m_err ? m_err_addr % 1024 : 0));
    chk("err_addr_w2", 64'(err_addr2), 64'(m_err ? m_err_addr % 4 : 0));
  endtask

  task automatic chk_log(input string n, input int idx, input logic [31:0] ei, input int ea);
    chk({n, "_present"}, 64'(log_i.size() > idx), 64'd1);
    if (log_i.size() > idx) begin
      chk({n, "_instr"}, 64'(log_i[idx]), 64'(ei));
      chk({n, "_addr"}, 64'(log_a[idx]), 64'(ea));
    end
  endtask

  function automatic logic [31:0] rand_imm();
    int bl[16];
    bl = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
           1048574, -1048576, 1048576, -1048578, 32'h12345000, 32'hFFFFF000, 32'h1001};
    case ($urandom_range(0, 5))
      0: return 32'(int'($urandom_range(0, 8000)) - 4000);
      1: return 32'(bl[$urandom_range(0, 15)]);
      2: return $urandom;
      3: return $urandom & 32'hFFFFF000;
      4: return 32'((int'($urandom_range(0, 4000000)) - 2000000) & ~1);
      default: return 32'($urandom_range(0, 63) * 2);
    endcase
  endfunction

  logic [4:0] ops[12];
  bit         rdone;
  int         base;

  initial begin
    ops = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100, 5'b01101,
            5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b00011, 5'b11111};
    rst_n = 0; clr = 0; in_valid = 0; out_ready = 1;
    opcode = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; imm = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk_err();
    rst_n = 1;
    @(posedge clk);
    #1;

    // ADDI x1,x0,-1 with exact latency
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
    chk("lat_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_instr", 64'(instr), 64'hFFF00093);
    chk("lat_addr", 64'(addr), 64'd0);
    wait_idle();

    // SW x2,8(x3) then LUI x5
    do_clear();
    base = log_i.size();
    send(5'b01000, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'd8);
    send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    wait_idle();
    chk_log("sw", base, 32'h0021A423, 0);
    chk_log("lui", base + 1, 32'h123452B7, 1);

    // JAL good, JAL out of range, then ADDI at unchanged addr
    do_clear();
    base = log_i.size();
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
    wait_idle();
    chk("jal_err", 64'(range_err), 64'd1);
    chk("jal_err_addr", 64'(err_addr), 64'd1);
    chk_err();
    send(5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    wait_idle();
    chk_log("jal", base, 32'h001000EF, 0);
    chk_log("after_jal", base + 1, 32'h00500013, 1);

    // clear, then odd branch dropped, ADDI takes its addr
    do_clear();
    chk("clear_err", 64'(range_err), 64'd0);
    chk_err();
    base = log_i.size();
    send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send(5'b00100, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    wait_idle();
    chk("br_err", 64'(range_err), 64'd1);
    chk("br_err_addr", 64'(err_addr), 64'd0);
    chk_log("br_addi", base, 32'h00500013, 0);

    // Four ADDIs with a 3-cycle consumer stall, then a fifth for ADDR_W=2 wrap
    do_clear();
    base = log_i.size();
    saw_full = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(5'b00100, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    send(5'b00100, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    wait_idle();
    chk("stall_in_ready_fell", 64'(saw_full), 64'd1);
    chk("stream_count", 64'(log_i.size()), 64'(base + 5));
    for (int i = 0; i < 4; i++)
      chk_log("stream", base + i, (32'(i) << 20) + (32'(i + 1) << 7) + 32'h13, i);
    if (log_a2.size() > base + 4) begin
      for (int i = 0; i < 5; i++) chk("wrap_addr2", 64'(log_a2[base + i]), 64'(i % 4));
    end

    // clear coinciding with an emitting transfer and with a drop
    do_clear();
    model_on = 0;
    base = log_i.size();
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    wait_idle();
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    send(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    wait_idle();
    chk_log("clr_emit", base + 1, 32'h00200113, 1);
    chk_log("clr_next", base + 2, 32'h00300193, 0);
    send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    clr = 1;
    @(posedge clk);
    #1 clr = 0;
    wait_idle();
    chk("clr_drop_err", 64'(range_err), 64'd0);
    chk("clr_drop_err_addr", 64'(err_addr), 64'd0);
    do_clear();
    model_on = 1;

    // randomized traffic with random backpressure
    rdone = 0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
          send(ops[$urandom_range(0, 11)], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), rand_imm());
          if (n == 200 && $urandom_range(0, 1) == 0) begin
            wait_idle();
            chk_err();
            do_clear();
          end
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1;
      end
    join
    wait_idle();
    chk_err();
    chk("queue_drained", 64'(q.size()), 64'd0);

    // asynchronous reset with both stages full
    model_on = 0;
    base = log_i.size();
    out_ready = 0;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_addr", 64'(addr), 64'd0);
    chk("arst_instr", 64'(instr), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_addr2", 64'(addr2), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    out_ready = 1;
    q.delete();
    m_cnt = 0; m_err = 0; m_err_addr = 0;
    model_on = 1;
    send(5'b00100, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    wait_idle();
    chk("arst_words", 64'(log_i.size()), 64'(base + 1));
    chk_log("arst_after", base, 32'h00400393, 0);
    chk("final_queue", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_instr_encoder.md
Name: rv32_instr_encoder

Overview:
- Inverse of the core's immediate decode path: accepts instruction fields plus a flat 32-bit immediate and packs them into a legal RV32I instruction word.
- Scatters immediate bits per format (I/S/B/U/J) and range-checks the immediate.
- Emits packed words with a running word address, for the board-side program loader that fills instruction memory.
- Two-stage valid/ready pipeline with full backpressure.
- Range-violating requests are dropped and reported through a sticky error flag.

Parameters:
- ADDR_W, 10, width of the output word-address counter.
- BASE_ADDR, 0, address-counter value after reset and after clear.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous; resets addr counter and error state; pipeline contents are kept.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- opcode  input  5  instruction bits [6:2], encoded with the shared opcode defines.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (R-type only).
- imm  input  32  flat immediate: byte offset for B/J; full value with low 12 bits zero for U.
- out_valid  output  1  packed word valid.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- instr  output  32  packed instruction; bits [1:0] always 2'b11.
- addr  output  ADDR_W  word address belonging to instr.
- range_err  output  1  sticky; set on the first dropped request.
- err_addr  output  ADDR_W  addr value at the first dropped request.

Behaviour:
- Reset values: in_ready=1, out_valid=0, instr=0, addr=BASE_ADDR, range_err=0, err_addr=0. Pipeline is emptied.
- Format is chosen by opcode:
  - I: Arith_I, Load, JALR, SYSTEM.
  - S: Store.
  - B: Branch.
  - U: LUI, AUIPC.
  - J: JAL.
  - R: Arith_R.
  - Any other opcode is packed as I-format.
- Range rules (imm treated as signed 32-bit):
  - I and S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never an error.
- Stage 1 registers the fields and a computed bad flag.
- Stage 2:
  - If bad: drop the request, do not advance addr, and set range_err/err_addr only if range_err is 0.
  - If good: register instr and the current addr, set out_valid, and post-increment the addr counter. The counter wraps modulo 2^ADDR_W.
- Latency: with out_ready held high, accept at cycle N gives out_valid/instr at N+2. Throughput is 1 word per cycle.
- Backpressure: each stage advances when it is empty or the stage below advances.
  - in_ready = !s1_valid || s1_adv (combinational).
  - instr/addr stay stable while out_valid && !out_ready.
- A dropped request in stage 2 frees its slot in the same cycle it would have been emitted.
- clear in the same cycle as an emitting stage-2 transfer: clear wins, so the next addr is BASE_ADDR. The word emitted in that cycle keeps its pre-clear addr.
- clear in the same cycle as a drop: range_err stays 0.
- Asynchronous reset mid-transfer: all in-flight words are discarded and outputs return to reset values immediately.
- Round-trip invariant: for every accepted good request, the core's immediate decode of instr equals imm; for U-format it equals {imm[31:12], 12'b0}.

Decomposition:
- Opcode constants and the format enumeration (FMT_R/I/S/B/U/J) go in the shared defines file.
- One combinational sub-module, rv32_imm_pack (fields + format -> 32-bit word), reused by the verification model.
- The range check stays inline in stage 1.

Test Plan:
- ADDI x1,x0,-1 (opcode Arith_I, rd=1, rs1=0, funct3=0, imm=-1) -> instr=0xFFF00093, addr=0, exactly 2 cycles after acceptance.
- SW x2,8(x3) (Store, rs1=3, rs2=2, funct3=010, imm=8), then LUI x5 imm=0x12345000 -> 0x0021A423 at addr 0, 0x123452B7 at addr 1.
- JAL x1,+2048 (rd=1, imm=0x800) -> 0x001000EF; JAL imm=1048576 -> dropped, range_err=1, err_addr=current addr, addr not advanced.
- Branch imm=3 then ADDI imm=5 -> branch dropped with range_err=1; ADDI emitted at the same addr the branch would have used.
- Stream of 4 ADDIs with out_ready low for 3 cycles mid-stream:
  - instr/addr hold steady while stalled.
  - in_ready falls once both stages are full.
  - No word is lost or duplicated; addrs are 0..3.
- ADDR_W=2 with 5 words -> addrs 0,1,2,3,0.
- clear pulse -> next addr=BASE_ADDR and range_err=0.
- rst_n low mid-stream -> out_valid=0 at once, addr=BASE_ADDR.
